adder_4bit_bist: RTL

//  Hardware stimulus/check stage that sits directly upstream of the 4-bit adder.

---
 rtl/adder_4bit_bist_pkg.sv | 19 +
 rtl/adder_4bit_bist_vec_cnt.sv | 48 ++++
 rtl/adder_4bit_bist.sv | 126 ++++++++++++
 3 files changed

// File: rtl/adder_4bit_bist_pkg.sv
// Shared definitions for the adder self-test stage: FSM state encoding,
// result counter width and the saturating increment used on mismatches.
package adder_4bit_bist_pkg;

  localparam int ERR_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/adder_4bit_bist_vec_cnt.sv
// Vector counter for the adder self-test: clears on run start, steps once per
// checked vector, and flags the final {ci,a,b} vector one cycle ahead via a register.
module adder_4bit_bist_vec_cnt #(
  parameter int WIDTH    = 4,
  parameter bit CI_SWEEP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [2*WIDTH:0] vec_o,
  output logic             last_o
);

  localparam logic [2*WIDTH:0] LAST_VEC = {CI_SWEEP, {(2*WIDTH){1'b1}}};

  logic [2*WIDTH:0] vec_q, vec_d;
  logic             last_q, last_d;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    vec_d = vec_q;
    if (clr) begin
      vec_d = '0;
    end else if (inc && !last_q) begin
      vec_d = vec_q + (2*WIDTH+1)'(1);
    end
    last_d = (vec_d == LAST_VEC);
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block rather
  // than listed in the sensitivity list; state uses non-blocking assignments so
  // all registers update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q  <= '0;
      last_q <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      last_q <= last_d;
    end
  end

  assign vec_o  = vec_q;
  assign last_o = last_q;

endmodule

// File: rtl/adder_4bit_bist.sv
// Built-in self-test stage for a WIDTH-bit adder: sweeps every {ci,a,b} operand,
// waits SETTLE cycles, compares {co,s} against a+b+ci and records the result.
module adder_4bit_bist
  import adder_4bit_bist_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit CI_SWEEP = 1'b0,
  parameter int SETTLE   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_o,
  output logic [WIDTH-1:0]     b_o,
  output logic                 ci_o,
  input  logic [WIDTH-1:0]     s_i,
  input  logic                 co_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 first_fail_vld,
  output logic [2*WIDTH:0]     first_fail_vec
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE > 0 ? SETTLE - 1 : 0);

  state_e                 state_q, state_d;
  logic [3:0]             settle_q, settle_d;
  logic [ERR_CNT_W-1:0]   err_q, err_d;
  logic                   pass_q, pass_d;
  logic                   ffv_q, ffv_d;
  logic [2*WIDTH:0]       ffvec_q, ffvec_d;
  logic [2*WIDTH:0]       vec;
  logic                   last;
  logic                   accept;
  logic [WIDTH:0]         golden;
  logic                   mismatch;

  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

  adder_4bit_bist_vec_cnt #(
    .WIDTH    (WIDTH),
    .CI_SWEEP (CI_SWEEP)
  ) u_vec_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .inc    (state_q == S_CHECK),
    .vec_o  (vec),
    .last_o (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_APPLY;
      S_APPLY:        state_d = (SETTLE == 0) ? S_CHECK : S_WAIT;
      S_WAIT:         if (settle_q == SETTLE_LAST) state_d = S_CHECK;
      S_CHECK:        state_d = last ? S_DONE : S_APPLY;
      default:        state_d = S_IDLE;
    endcase
  end

  // Operands come straight from the vector counter, so they only move on APPLY entry.
  always_comb begin
    a_o  = vec[2*WIDTH-1:WIDTH];
    b_o  = vec[WIDTH-1:0];
    ci_o = CI_SWEEP ? vec[2*WIDTH] : 1'b0;
    busy = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_CHECK);
    done = (state_q == S_DONE);
  end

  assign golden   = {1'b0, a_o} + {1'b0, b_o} + {{WIDTH{1'b0}}, ci_o};
  assign mismatch = ({co_i, s_i} != golden);
  assign settle_d = (state_q == S_WAIT) ? settle_q + 4'd1 : 4'd0;

  always_comb begin
    err_d   = err_q;
    pass_d  = pass_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    if (accept) begin
      err_d   = '0;
      pass_d  = 1'b0;
      ffv_d   = 1'b0;
      ffvec_d = '0;
    end else if (state_q == S_CHECK) begin
      if (mismatch) begin
        err_d = sat_inc(err_q);
        if (!ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = vec;
        end
      end
      if (last) pass_d = (err_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_q <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
    end else begin
      settle_q <= settle_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
    end
  end

  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_vec = ffvec_q;

endmodule
